// File: rtl/ruta_ctrl_pipe.sv
// ID-stage decode plus ID/EX, EX/MEM, MEM/WB control pipeline; bundles appear 1/2/3 edges after ID; stall holds PC/IF-ID and injects a bubble.
// Define RUTA_FWD_EN for forwarding selects (FWD_A/FWD_B) with load-use-only stalls; default build stalls on any RAW until the producer reaches WB.
module ruta_ctrl_pipe #(
  parameter int REG_AW = 5,
  parameter int ILL_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  output logic [1:0]        SEL_DIR,
  output logic              REG_RD,
  output logic              SEL_IM,
  output logic              stall,
  output logic              resetIF,
  output logic [4:0]        ctrl_EXE,
  output logic [2:0]        ctrl_MEM,
  output logic [1:0]        ctrl_WB,
  output logic [REG_AW-1:0] dst_ex,
  output logic [REG_AW-1:0] dst_mem,
  output logic [REG_AW-1:0] dst_wb,
  output logic [ILL_W-1:0]  ill_cnt
`ifdef RUTA_FWD_EN
  ,
  output logic [1:0]        FWD_A,
  output logic [1:0]        FWD_B
`endif
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_NOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;

  logic       dec_legal, dec_alusrc, dec_memrd, dec_memwr, dec_half;
  logic       dec_regwr, dec_m2r, dec_wr_rd, dec_use_rs, dec_use_rt;
  logic       dec_selim, dec_i_alu;
  logic [3:0] dec_aluop;
  logic [1:0] dec_seldir;

  always_comb begin
    dec_legal  = 1'b0;
    dec_alusrc = 1'b0;
    dec_memrd  = 1'b0;
    dec_memwr  = 1'b0;
    dec_half   = 1'b0;
    dec_regwr  = 1'b0;
    dec_m2r    = 1'b0;
    dec_wr_rd  = 1'b0;
    dec_use_rs = 1'b0;
    dec_use_rt = 1'b0;
    dec_selim  = 1'b0;
    dec_i_alu  = 1'b0;
    dec_aluop  = OP_ADD;
    dec_seldir = 2'b00;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin dec_legal = 1'b1; dec_aluop = OP_ADD; end
          6'h22: begin dec_legal = 1'b1; dec_aluop = OP_SUB; end
          6'h24: begin dec_legal = 1'b1; dec_aluop = OP_AND; end
          6'h25: begin dec_legal = 1'b1; dec_aluop = OP_OR;  end
          6'h27: begin dec_legal = 1'b1; dec_aluop = OP_NOR; end
          6'h2A: begin dec_legal = 1'b1; dec_aluop = OP_SLT; end
          6'h08: begin dec_legal = 1'b1; dec_seldir = 2'b10; end
          default: dec_legal = 1'b0;
        endcase
        dec_use_rs = dec_legal;
        if (dec_legal && funct != 6'h08) begin
          dec_regwr  = 1'b1;
          dec_wr_rd  = 1'b1;
          dec_use_rt = 1'b1;
        end
      end
      6'h08: begin dec_legal = 1'b1; dec_i_alu = 1'b1; dec_aluop = OP_ADD; end
      6'h0C: begin dec_legal = 1'b1; dec_i_alu = 1'b1; dec_aluop = OP_AND; end
      6'h0D: begin dec_legal = 1'b1; dec_i_alu = 1'b1; dec_aluop = OP_OR;  end
      6'h0A: begin dec_legal = 1'b1; dec_i_alu = 1'b1; dec_aluop = OP_SLT; end
      6'h23: begin
        dec_legal  = 1'b1;
        dec_alusrc = 1'b1;
        dec_memrd  = 1'b1;
        dec_regwr  = 1'b1;
        dec_m2r    = 1'b1;
        dec_use_rs = 1'b1;
      end
      // Stores still compute base+offset, so they take the immediate operand.
      6'h2B, 6'h29: begin
        dec_legal  = 1'b1;
        dec_alusrc = 1'b1;
        dec_memwr  = 1'b1;
        dec_half   = (opcode == 6'h29);
        dec_use_rs = 1'b1;
        dec_use_rt = 1'b1;
      end
      6'h02: begin dec_legal = 1'b1; dec_seldir = 2'b01; end
      default: dec_legal = 1'b0;
    endcase
    if (dec_i_alu) begin
      dec_alusrc = 1'b1;
      dec_selim  = 1'b1;
      dec_regwr  = 1'b1;
      dec_use_rs = 1'b1;
    end
  end

  logic              vld, rs_chk, rt_chk, is_jump;
  logic [REG_AW-1:0] dec_dst;

  assign vld     = id_valid & dec_legal;
  assign rs_chk  = vld & dec_use_rs;
  assign rt_chk  = vld & dec_use_rt;
  assign is_jump = vld & (dec_seldir != 2'b00);
  assign dec_dst = (vld & dec_regwr) ? (dec_wr_rd ? rd : rt) : '0;

  assign SEL_DIR = vld ? dec_seldir : 2'b00;
  assign REG_RD  = vld & (dec_seldir != 2'b01);
  assign SEL_IM  = vld & dec_selim;

  logic [4:0]        idex_exe_q, idex_exe_d;
  logic [2:0]        idex_mem_q, idex_mem_d;
  logic [1:0]        idex_wb_q, idex_wb_d;
  logic [REG_AW-1:0] idex_dst_q, idex_dst_d;
  logic [2:0]        exmem_mem_q;
  logic [1:0]        exmem_wb_q;
  logic [REG_AW-1:0] exmem_dst_q;
  logic [1:0]        memwb_wb_q;
  logic [REG_AW-1:0] memwb_dst_q;
  logic [ILL_W-1:0]  ill_q, ill_d;

  // Register 0 is hard-wired, so a zero destination never matches.
  function automatic logic raw_hit(input logic [REG_AW-1:0] d,
                                   input logic [REG_AW-1:0] a,
                                   input logic [REG_AW-1:0] b,
                                   input logic ua, input logic ub);
    return (d != '0) && ((ua && a == d) || (ub && b == d));
  endfunction

  logic load_use, stall_c;
  assign load_use = idex_mem_q[2] && raw_hit(idex_dst_q, rs, rt, rs_chk, rt_chk);

`ifdef RUTA_FWD_EN
  assign stall_c = load_use;

  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  // Select for the operand as seen next cycle: today's EX becomes MEM, today's MEM becomes WB.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] r, input logic used,
                                         input logic ex_wr, input logic [REG_AW-1:0] ex_dst,
                                         input logic mem_wr, input logic [REG_AW-1:0] mem_dst);
    if (!used || r == '0) return 2'b00;
    if (ex_wr && ex_dst == r) return 2'b01;
    if (mem_wr && mem_dst == r) return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (!stall_c) begin
      fwd_a_d = fwd_sel(rs, rs_chk, idex_wb_q[1], idex_dst_q, exmem_wb_q[1], exmem_dst_q);
      fwd_b_d = fwd_sel(rt, rt_chk, idex_wb_q[1], idex_dst_q, exmem_wb_q[1], exmem_dst_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign FWD_A = fwd_a_q;
  assign FWD_B = fwd_b_q;
`else
  logic raw_ex, raw_mem;
  assign raw_ex  = idex_wb_q[1]  && raw_hit(idex_dst_q,  rs, rt, rs_chk, rt_chk);
  assign raw_mem = exmem_wb_q[1] && raw_hit(exmem_dst_q, rs, rt, rs_chk, rt_chk);
  assign stall_c = load_use | raw_ex | raw_mem;
`endif

  assign stall   = rst_n & stall_c;
  assign resetIF = rst_n & is_jump & ~stall_c;

  always_comb begin
    idex_exe_d = '0;
    idex_mem_d = '0;
    idex_wb_d  = '0;
    idex_dst_d = '0;
    if (vld && !stall_c) begin
      idex_exe_d = {dec_alusrc, dec_aluop};
      idex_mem_d = {dec_memrd, dec_memwr, dec_half};
      idex_wb_d  = {dec_regwr, dec_m2r};
      idex_dst_d = dec_dst;
    end
    ill_d = ill_q;
    if (id_valid && !dec_legal && !stall_c && ill_q != {ILL_W{1'b1}})
      ill_d = ill_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_exe_q  <= '0;
      idex_mem_q  <= '0;
      idex_wb_q   <= '0;
      idex_dst_q  <= '0;
      exmem_mem_q <= '0;
      exmem_wb_q  <= '0;
      exmem_dst_q <= '0;
      memwb_wb_q  <= '0;
      memwb_dst_q <= '0;
      ill_q       <= '0;
    end else begin
      idex_exe_q  <= idex_exe_d;
      idex_mem_q  <= idex_mem_d;
      idex_wb_q   <= idex_wb_d;
      idex_dst_q  <= idex_dst_d;
      exmem_mem_q <= idex_mem_q;
      exmem_wb_q  <= idex_wb_q;
      exmem_dst_q <= idex_dst_q;
      memwb_wb_q  <= exmem_wb_q;
      memwb_dst_q <= exmem_dst_q;
      ill_q       <= ill_d;
    end
  end

  assign ctrl_EXE = idex_exe_q;
  assign ctrl_MEM = exmem_mem_q;
  assign ctrl_WB  = memwb_wb_q;
  assign dst_ex   = idex_dst_q;
  assign dst_mem  = exmem_dst_q;
  assign dst_wb   = memwb_dst_q;
  assign ill_cnt  = ill_q;

endmodule

// File: tb/tb_ruta_ctrl_pipe.sv
// Directed bench for ruta_ctrl_pipe; expectations adapt to RUTA_FWD_EN when it is defined.
module tb_ruta_ctrl_pipe;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic [4:0] rs = '0, rt = '0, rd = '0;
  logic [1:0] SEL_DIR;
  logic       REG_RD, SEL_IM, stall, resetIF;
  logic [4:0] ctrl_EXE;
  logic [2:0] ctrl_MEM;
  logic [1:0] ctrl_WB;
  logic [4:0] dst_ex, dst_mem, dst_wb;
  logic [7:0] ill_cnt;
`ifdef RUTA_FWD_EN
  logic [1:0] FWD_A, FWD_B;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  ruta_ctrl_pipe #(.REG_AW(5), .ILL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .SEL_DIR(SEL_DIR), .REG_RD(REG_RD), .SEL_IM(SEL_IM),
    .stall(stall), .resetIF(resetIF), .ctrl_EXE(ctrl_EXE), .ctrl_MEM(ctrl_MEM),
    .ctrl_WB(ctrl_WB), .dst_ex(dst_ex), .dst_mem(dst_mem), .dst_wb(dst_wb),
    .ill_cnt(ill_cnt)
`ifdef RUTA_FWD_EN
    , .FWD_A(FWD_A), .FWD_B(FWD_B)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    id_valid = v; opcode = op; funct = fn; rs = s; rt = t; rd = d;
    #1;
  endtask

  task automatic nop_flush(input int n);
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    drive(1'b1, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0);
    n_cmp++; if (resetIF !== 1'b0) begin n_bad++; $display("FAIL rst_resetIF: got %b want 0", resetIF); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", stall); end
    tick(); tick();
    n_cmp++; if ({ctrl_EXE, ctrl_MEM, ctrl_WB} !== 10'd0) begin n_bad++; $display("FAIL rst_bundles: got %h want 0", {ctrl_EXE, ctrl_MEM, ctrl_WB}); end
    n_cmp++; if ({dst_ex, dst_mem, dst_wb, ill_cnt} !== 23'd0) begin n_bad++; $display("FAIL rst_dst_cnt: got %h want 0", {dst_ex, dst_mem, dst_wb, ill_cnt}); end
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    drive(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3);
    n_cmp++; if ({SEL_DIR, REG_RD, SEL_IM, stall} !== 5'b00100) begin n_bad++; $display("FAIL add_idctl: got %b want 00100", {SEL_DIR, REG_RD, SEL_IM, stall}); end
    tick();
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    n_cmp++; if ({ctrl_EXE, dst_ex} !== {5'b00000, 5'd3}) begin n_bad++; $display("FAIL add_ex: got %b/%0d want 00000/3", ctrl_EXE, dst_ex); end
    tick(); tick();
    n_cmp++; if ({ctrl_WB, dst_wb} !== {2'b10, 5'd3}) begin n_bad++; $display("FAIL add_wb: got %b/%0d want 10/3", ctrl_WB, dst_wb); end
    tick();
  endtask

  logic [5:0] bb_op  [11] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23};
  logic [5:0] bb_fn  [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
  logic [4:0] bb_exe [11] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                              5'b10000, 5'b10010, 5'b10011, 5'b10101, 5'b10000};

  task automatic test_back_to_back();
    for (int i = 0; i < 11; i++) begin
      logic [4:0] dreg;
      dreg = 5'(10 + i);
      if (bb_op[i] == 6'h00) drive(1'b1, bb_op[i], bb_fn[i], 5'd0, 5'd0, dreg);
      else drive(1'b1, bb_op[i], bb_fn[i], 5'd0, dreg, 5'd0);
      tick();
      n_cmp++; if ({ctrl_EXE, dst_ex} !== {bb_exe[i], dreg}) begin n_bad++; $display("FAIL b2b_%0d: got %b/%0d want %b/%0d", i, ctrl_EXE, dst_ex, bb_exe[i], dreg); end
    end
    nop_flush(3);
  endtask

  task automatic test_mem();
    drive(1'b1, 6'h23, 6'h00, 5'd0, 5'd7, 5'd0);
    tick();
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    tick();
    n_cmp++; if ({ctrl_MEM, dst_mem} !== {3'b100, 5'd7}) begin n_bad++; $display("FAIL lw_mem: got %b/%0d want 100/7", ctrl_MEM, dst_mem); end
    tick();
    n_cmp++; if ({ctrl_WB, dst_wb} !== {2'b11, 5'd7}) begin n_bad++; $display("FAIL lw_wb: got %b/%0d want 11/7", ctrl_WB, dst_wb); end
    drive(1'b1, 6'h2B, 6'h00, 5'd0, 5'd7, 5'd0);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL sw_producer_in_wb_stall: got %b want 0", stall); end
    tick();
    drive(1'b1, 6'h29, 6'h00, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    n_cmp++; if (ctrl_MEM !== 3'b010) begin n_bad++; $display("FAIL sw_mem: got %b want 010", ctrl_MEM); end
    tick();
    n_cmp++; if ({ctrl_MEM, ctrl_WB} !== {3'b011, 2'b00}) begin n_bad++; $display("FAIL sh_mem_sw_wb: got %b/%b want 011/00", ctrl_MEM, ctrl_WB); end
    nop_flush(3);
  endtask

  task automatic test_load_use();
    int cnt, exp_cnt;
    logic [4:0] bub_dst;
`ifdef RUTA_FWD_EN
    exp_cnt = 1;
`else
    exp_cnt = 2;
`endif
    cnt = 0; bub_dst = 5'h1F;
    drive(1'b1, 6'h23, 6'h00, 5'd0, 5'd5, 5'd0);
    tick();
    drive(1'b1, 6'h00, 6'h20, 5'd5, 5'd0, 5'd6);
    for (int k = 0; k < 6 && stall === 1'b1; k++) begin
      cnt++;
      tick();
      if (k == 0) bub_dst = dst_ex;
    end
    n_cmp++; if (cnt !== exp_cnt) begin n_bad++; $display("FAIL lu_stall_cycles: got %0d want %0d", cnt, exp_cnt); end
    n_cmp++; if (bub_dst !== 5'd0) begin n_bad++; $display("FAIL lu_bubble_dst: got %0d want 0", bub_dst); end
    tick();
    n_cmp++; if ({ctrl_EXE, dst_ex} !== {5'b00000, 5'd6}) begin n_bad++; $display("FAIL lu_add_ex: got %b/%0d want 00000/6", ctrl_EXE, dst_ex); end
`ifdef RUTA_FWD_EN
    n_cmp++; if (FWD_A !== 2'b10) begin n_bad++; $display("FAIL lu_fwd_a: got %b want 10", FWD_A); end
`endif
    nop_flush(3);
  endtask

  task automatic test_raw();
    int cnt, exp_cnt;
`ifdef RUTA_FWD_EN
    exp_cnt = 0;
`else
    exp_cnt = 2;
`endif
    cnt = 0;
    drive(1'b1, 6'h08, 6'h00, 5'd0, 5'd4, 5'd0);
    tick();
    drive(1'b1, 6'h00, 6'h22, 5'd4, 5'd0, 5'd8);
    for (int k = 0; k < 6 && stall === 1'b1; k++) begin
      cnt++;
      tick();
    end
    n_cmp++; if (cnt !== exp_cnt) begin n_bad++; $display("FAIL raw_stall_cycles: got %0d want %0d", cnt, exp_cnt); end
    tick();
    n_cmp++; if ({ctrl_EXE, dst_ex} !== {5'b00001, 5'd8}) begin n_bad++; $display("FAIL raw_sub_ex: got %b/%0d want 00001/8", ctrl_EXE, dst_ex); end
`ifdef RUTA_FWD_EN
    n_cmp++; if (FWD_A !== 2'b01) begin n_bad++; $display("FAIL raw_fwd_a: got %b want 01", FWD_A); end
`endif
    nop_flush(3);
  endtask

  task automatic test_reg0();
    drive(1'b1, 6'h23, 6'h00, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1'b1, 6'h00, 6'h20, 5'd0, 5'd0, 5'd6);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reg0_stall: got %b want 0", stall); end
    tick();
    nop_flush(3);
  endtask

  task automatic test_jump();
    logic exp_rif;
    drive(1'b1, 6'h02, 6'h00, 5'd3, 5'd3, 5'd3);
    n_cmp++; if ({SEL_DIR, resetIF, REG_RD} !== 4'b0110) begin n_bad++; $display("FAIL j_id: got %b want 0110", {SEL_DIR, resetIF, REG_RD}); end
    tick();
    drive(1'b0, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0);
    n_cmp++; if ({SEL_DIR, resetIF} !== 3'b000) begin n_bad++; $display("FAIL j_invalid: got %b want 000", {SEL_DIR, resetIF}); end
    tick(); tick();
    n_cmp++; if ({ctrl_WB, dst_wb} !== 7'd0) begin n_bad++; $display("FAIL j_wb: got %b/%0d want 00/0", ctrl_WB, dst_wb); end
    drive(1'b1, 6'h00, 6'h08, 5'd0, 5'd0, 5'd0);
    n_cmp++; if ({SEL_DIR, resetIF, REG_RD} !== 4'b1011) begin n_bad++; $display("FAIL jr_id: got %b want 1011", {SEL_DIR, resetIF, REG_RD}); end
    tick();
`ifdef RUTA_FWD_EN
    exp_rif = 1'b1;
`else
    exp_rif = 1'b0;
`endif
    drive(1'b1, 6'h08, 6'h00, 5'd0, 5'd4, 5'd0);
    tick();
    drive(1'b1, 6'h00, 6'h08, 5'd4, 5'd0, 5'd0);
    n_cmp++; if ({stall, resetIF} !== {~exp_rif, exp_rif}) begin n_bad++; $display("FAIL jr_stall_prio: got %b want %b", {stall, resetIF}, {~exp_rif, exp_rif}); end
    nop_flush(4);
  endtask

  task automatic test_illegal();
    drive(1'b0, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3);
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (ill_cnt !== 8'd0) begin n_bad++; $display("FAIL ill_invalid: got %0d want 0", ill_cnt); end
    drive(1'b1, 6'h00, 6'h01, 5'd1, 5'd2, 5'd3);
    tick();
    n_cmp++; if ({ill_cnt, ctrl_EXE, dst_ex} !== {8'd1, 5'd0, 5'd0}) begin n_bad++; $display("FAIL ill_first: got %0d/%b/%0d want 1/00000/0", ill_cnt, ctrl_EXE, dst_ex); end
    drive(1'b1, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3);
    for (int i = 0; i < 253; i++) tick();
    n_cmp++; if (ill_cnt !== 8'd254) begin n_bad++; $display("FAIL ill_254: got %0d want 254", ill_cnt); end
    for (int i = 0; i < 46; i++) tick();
    n_cmp++; if (ill_cnt !== 8'd255) begin n_bad++; $display("FAIL ill_sat: got %0d want 255", ill_cnt); end
    drive(1'b0, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3);
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (ill_cnt !== 8'd255) begin n_bad++; $display("FAIL ill_hold: got %0d want 255", ill_cnt); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 6'h23, 6'h00, 5'd0, 5'd7, 5'd0);
    tick();
    drive(1'b1, 6'h00, 6'h20, 5'd0, 5'd0, 5'd2);
    tick();
    n_cmp++; if (ctrl_MEM !== 3'b100) begin n_bad++; $display("FAIL mid_pre_mem: got %b want 100", ctrl_MEM); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({ctrl_EXE, ctrl_MEM, ctrl_WB, dst_ex, dst_mem, dst_wb} !== 25'd0) begin n_bad++; $display("FAIL mid_async_clear: got %h want 0", {ctrl_EXE, ctrl_MEM, ctrl_WB, dst_ex, dst_mem, dst_wb}); end
    n_cmp++; if ({ill_cnt, stall} !== 9'd0) begin n_bad++; $display("FAIL mid_cnt_stall: got %h want 0", {ill_cnt, stall}); end
    drive(1'b1, 6'h00, 6'h20, 5'd0, 5'd0, 5'd9);
    tick(); tick();
    n_cmp++; if (dst_ex !== 5'd0) begin n_bad++; $display("FAIL mid_hold: got %0d want 0", dst_ex); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    n_cmp++; if ({ctrl_EXE, dst_ex} !== {5'b00000, 5'd9}) begin n_bad++; $display("FAIL mid_first_after: got %b/%0d want 00000/9", ctrl_EXE, dst_ex); end
    nop_flush(3);
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mem();
    test_load_use();
    test_raw();
    test_reg0();
    test_jump();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
